// File: rtl/free_list_if.sv
// Rename-stage free-list bundle: dispatch allocation, ROB commit release and flush.
// The free list itself connects on the slave side; dispatch/ROB drive the master side.
interface free_list_if #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int ARCH_REGS      = 64,
  parameter int PHYS_REGS      = 128
);
  localparam int N     = PHYS_REGS - ARCH_REGS;
  localparam int PRF_W = $clog2(PHYS_REGS);
  localparam int CNT_W = $clog2(N + 1);

  logic [DISPATCH_WIDTH-1:0]            alloc_req_i;
  logic [DISPATCH_WIDTH-1:0]            alloc_gnt_o;
  logic [DISPATCH_WIDTH-1:0][PRF_W-1:0] alloc_prf_o;
  logic [CNT_W-1:0]                     free_count_o;
  logic [COMMIT_WIDTH-1:0]              commit_valid_i;
  logic [COMMIT_WIDTH-1:0]              commit_rd_wen_i;
  logic [COMMIT_WIDTH-1:0][PRF_W-1:0]   commit_old_prf_i;
  logic                                 flush_i;

  modport slave (
    input  alloc_req_i, commit_valid_i, commit_rd_wen_i, commit_old_prf_i, flush_i,
    output alloc_gnt_o, alloc_prf_o, free_count_o
  );

  modport master (
    output alloc_req_i, commit_valid_i, commit_rd_wen_i, commit_old_prf_i, flush_i,
    input  alloc_gnt_o, alloc_prf_o, free_count_o
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags, allocated at head,
// refilled at tail by committed old mappings, restored to committed state on flush.
module free_list #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int ARCH_REGS      = 64,
  parameter int PHYS_REGS      = 128
) (
  input logic        clock,
  input logic        reset_n,
  free_list_if.slave fl_if
);
  localparam int N     = PHYS_REGS - ARCH_REGS;
  localparam int PRF_W = $clog2(PHYS_REGS);
  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  // N need not be a power of two, so wrap by compare rather than truncation.
  function automatic ptr_t ptr_add(input ptr_t p, input int unsigned inc);
    int unsigned s;
    s = 32'(p) + inc;
    if (s >= 32'(N)) s = s - 32'(N);
    return ptr_t'(s);
  endfunction

  logic [PRF_W-1:0] fl_q [N];
  logic [PRF_W-1:0] fl_d [N];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DISPATCH_WIDTH-1:0]            gnt;
  logic [DISPATCH_WIDTH-1:0][PRF_W-1:0] prf;
  int unsigned                          n_gnt;
  int unsigned                          n_rel;
  int unsigned                          n_rel_req;
  int unsigned                          room;

  always_comb begin
    n_gnt = 0;
    gnt   = '0;
    prf   = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (reset_n && fl_if.alloc_req_i[i] && (n_gnt < 32'(count_q))) begin
        gnt[i] = 1'b1;
        prf[i] = fl_q[ptr_add(head_q, n_gnt)];
        n_gnt  = n_gnt + 1;
      end
    end
  end

  // Releases beyond what the FIFO can hold are a protocol error and are dropped.
  always_comb begin
    fl_d      = fl_q;
    n_rel     = 0;
    n_rel_req = 0;
    room      = 32'(N) - (32'(count_q) - n_gnt);
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (fl_if.commit_valid_i[k] && fl_if.commit_rd_wen_i[k]) begin
        n_rel_req = n_rel_req + 1;
        if (n_rel < room) begin
          fl_d[ptr_add(tail_q, n_rel)] = fl_if.commit_old_prf_i[k];
          n_rel = n_rel + 1;
        end
      end
    end
    tail_d = ptr_add(tail_q, n_rel);
    if (fl_if.flush_i) begin
      head_d  = tail_d;
      count_d = CNT_W'(N);
    end else begin
      head_d  = ptr_add(head_q, n_gnt);
      count_d = CNT_W'(32'(count_q) + n_rel - n_gnt);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) fl_q[i] <= PRF_W'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(N);
    end else begin
      fl_q    <= fl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assert property (@(posedge clock) disable iff (!reset_n)
                   (32'(count_q) + n_rel_req - n_gnt) <= 32'(N));

  assign fl_if.alloc_gnt_o  = gnt;
  assign fl_if.alloc_prf_o  = prf;
  assign fl_if.free_count_o = count_q;
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation order, exhaustion, flush restore,
// wrap-around and asynchronous reset, each against hand-computed tags and counts.
module tb_free_list;
  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  free_list_if bus ();

  free_list dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fl_if   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic idle();
    bus.alloc_req_i      = '0;
    bus.commit_valid_i   = '0;
    bus.commit_rd_wen_i  = '0;
    bus.commit_old_prf_i = '0;
    bus.flush_i          = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    bus.alloc_req_i = 2'b11;
    @(negedge clock);
    #1;
    n_cmp++;
    if (bus.alloc_gnt_o !== 2'b00) begin
      n_bad++; $display("FAIL reset_gnt: got %b want 00", bus.alloc_gnt_o);
    end
    n_cmp++;
    if (bus.alloc_prf_o !== '0) begin
      n_bad++; $display("FAIL reset_prf: got %h want 0", bus.alloc_prf_o);
    end
    n_cmp++;
    if (bus.free_count_o !== 7'd64) begin
      n_bad++; $display("FAIL reset_count: got %0d want 64", bus.free_count_o);
    end
    idle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_alloc_basic();
    do_reset();
    bus.alloc_req_i = 2'b11;
    #1;
    n_cmp++;
    if (bus.alloc_gnt_o !== 2'b11 || bus.alloc_prf_o[0] !== 7'd64 || bus.alloc_prf_o[1] !== 7'd65) begin
      n_bad++; $display("FAIL basic_first: got gnt=%b prf0=%0d prf1=%0d want 11/64/65",
                        bus.alloc_gnt_o, bus.alloc_prf_o[0], bus.alloc_prf_o[1]);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd62) begin
      n_bad++; $display("FAIL basic_count: got %0d want 62", bus.free_count_o);
    end
    n_cmp++;
    if (bus.alloc_prf_o[0] !== 7'd66 || bus.alloc_prf_o[1] !== 7'd67) begin
      n_bad++; $display("FAIL basic_second: got %0d/%0d want 66/67", bus.alloc_prf_o[0], bus.alloc_prf_o[1]);
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_exhaust();
    do_reset();
    bus.alloc_req_i = 2'b11;
    repeat (32) @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd0) begin
      n_bad++; $display("FAIL exhaust_count: got %0d want 0", bus.free_count_o);
    end
    bus.alloc_req_i         = 2'b01;
    bus.commit_valid_i      = 2'b01;
    bus.commit_rd_wen_i     = 2'b01;
    bus.commit_old_prf_i[0] = 7'd5;
    #1;
    n_cmp++;
    if (bus.alloc_gnt_o !== 2'b00) begin
      n_bad++; $display("FAIL exhaust_nobypass: got gnt=%b want 00", bus.alloc_gnt_o);
    end
    @(negedge clock);
    bus.commit_valid_i  = '0;
    bus.commit_rd_wen_i = '0;
    #1;
    n_cmp++;
    if (bus.alloc_gnt_o !== 2'b01 || bus.alloc_prf_o[0] !== 7'd5) begin
      n_bad++; $display("FAIL exhaust_reuse: got gnt=%b prf0=%0d want 01/5", bus.alloc_gnt_o, bus.alloc_prf_o[0]);
    end
    n_cmp++;
    if (bus.free_count_o !== 7'd1) begin
      n_bad++; $display("FAIL exhaust_count1: got %0d want 1", bus.free_count_o);
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_flush_restore();
    do_reset();
    bus.alloc_req_i = 2'b11;
    repeat (5) @(negedge clock);
    idle();
    bus.commit_valid_i      = 2'b11;
    bus.commit_rd_wen_i     = 2'b11;
    bus.commit_old_prf_i[0] = 7'd0;
    bus.commit_old_prf_i[1] = 7'd1;
    @(negedge clock);
    bus.commit_valid_i      = 2'b01;
    bus.commit_rd_wen_i     = 2'b01;
    bus.commit_old_prf_i[0] = 7'd2;
    @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd57) begin
      n_bad++; $display("FAIL flush_precount: got %0d want 57", bus.free_count_o);
    end
    bus.flush_i = 1'b1;
    @(negedge clock);
    bus.flush_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd64) begin
      n_bad++; $display("FAIL flush_count: got %0d want 64", bus.free_count_o);
    end
    bus.alloc_req_i = 2'b11;
    #1;
    n_cmp++;
    if (bus.alloc_prf_o[0] !== 7'd67 || bus.alloc_prf_o[1] !== 7'd68) begin
      n_bad++; $display("FAIL flush_head: got %0d/%0d want 67/68", bus.alloc_prf_o[0], bus.alloc_prf_o[1]);
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_flush_with_commit();
    do_reset();
    bus.alloc_req_i = 2'b11;
    repeat (2) @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd60) begin
      n_bad++; $display("FAIL fcommit_precount: got %0d want 60", bus.free_count_o);
    end
    bus.alloc_req_i         = 2'b11;
    bus.commit_valid_i      = 2'b11;
    bus.commit_rd_wen_i     = 2'b11;
    bus.commit_old_prf_i[0] = 7'd3;
    bus.commit_old_prf_i[1] = 7'd4;
    bus.flush_i             = 1'b1;
    @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd64) begin
      n_bad++; $display("FAIL fcommit_count: got %0d want 64", bus.free_count_o);
    end
    bus.alloc_req_i = 2'b11;
    for (int c = 0; c < 31; c++) begin
      #1;
      n_cmp++;
      if (bus.alloc_prf_o[0] !== 7'(66 + 2 * c) || bus.alloc_prf_o[1] !== 7'(67 + 2 * c)) begin
        n_bad++; $display("FAIL fcommit_seq%0d: got %0d/%0d want %0d/%0d", c,
                          bus.alloc_prf_o[0], bus.alloc_prf_o[1], 66 + 2 * c, 67 + 2 * c);
      end
      @(negedge clock);
    end
    #1;
    n_cmp++;
    if (bus.alloc_gnt_o !== 2'b11 || bus.alloc_prf_o[0] !== 7'd3 || bus.alloc_prf_o[1] !== 7'd4) begin
      n_bad++; $display("FAIL fcommit_tail: got gnt=%b %0d/%0d want 11/3/4",
                        bus.alloc_gnt_o, bus.alloc_prf_o[0], bus.alloc_prf_o[1]);
    end
    @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd0) begin
      n_bad++; $display("FAIL fcommit_empty: got %0d want 0", bus.free_count_o);
    end
  endtask

  task automatic test_wrap();
    int          model[$];
    int          exp0, exp1;
    logic [6:0]  t;
    logic [127:0] seen;
    do_reset();
    model.delete();
    for (int i = 0; i < 64; i++) model.push_back(64 + i);
    for (int c = 0; c < 70; c++) begin
      bus.alloc_req_i = 2'b01;
      #1;
      t    = bus.alloc_prf_o[0];
      exp0 = model.pop_front();
      model.push_back(exp0);
      n_cmp++;
      if (bus.alloc_gnt_o !== 2'b01 || t !== 7'(exp0)) begin
        n_bad++; $display("FAIL wrap_tag%0d: got gnt=%b prf=%0d want 01/%0d", c, bus.alloc_gnt_o, t, exp0);
      end
      bus.commit_valid_i      = 2'b11;
      bus.commit_rd_wen_i     = 2'b01;
      bus.commit_old_prf_i[0] = t;
      bus.commit_old_prf_i[1] = 7'd17;
      @(negedge clock);
      n_cmp++;
      if (bus.free_count_o !== 7'd64) begin
        n_bad++; $display("FAIL wrap_count%0d: got %0d want 64", c, bus.free_count_o);
      end
    end
    idle();
    seen = '0;
    bus.alloc_req_i = 2'b11;
    for (int c = 0; c < 32; c++) begin
      #1;
      exp0 = model.pop_front();
      exp1 = model.pop_front();
      n_cmp++;
      if (bus.alloc_prf_o[0] !== 7'(exp0) || bus.alloc_prf_o[1] !== 7'(exp1)) begin
        n_bad++; $display("FAIL wrap_drain%0d: got %0d/%0d want %0d/%0d", c,
                          bus.alloc_prf_o[0], bus.alloc_prf_o[1], exp0, exp1);
      end
      n_cmp++;
      if (seen[bus.alloc_prf_o[0]] || seen[bus.alloc_prf_o[1]] || bus.alloc_prf_o[0] == bus.alloc_prf_o[1]) begin
        n_bad++; $display("FAIL wrap_unique%0d: duplicate tag %0d/%0d want distinct", c,
                          bus.alloc_prf_o[0], bus.alloc_prf_o[1]);
      end
      seen[bus.alloc_prf_o[0]] = 1'b1;
      seen[bus.alloc_prf_o[1]] = 1'b1;
      @(negedge clock);
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.alloc_req_i = 2'b11;
    repeat (22) @(negedge clock);
    idle();
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd20) begin
      n_bad++; $display("FAIL areset_pre: got %0d want 20", bus.free_count_o);
    end
    #1;
    bus.alloc_req_i = 2'b11;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.free_count_o !== 7'd64 || bus.alloc_gnt_o !== 2'b00) begin
      n_bad++; $display("FAIL areset_now: got count=%0d gnt=%b want 64/00", bus.free_count_o, bus.alloc_gnt_o);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.alloc_gnt_o !== 2'b11 || bus.alloc_prf_o[0] !== 7'd64 || bus.alloc_prf_o[1] !== 7'd65) begin
      n_bad++; $display("FAIL areset_first: got gnt=%b %0d/%0d want 11/64/65",
                        bus.alloc_gnt_o, bus.alloc_prf_o[0], bus.alloc_prf_o[1]);
    end
    @(negedge clock);
    idle();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_alloc_basic();
    test_exhaust();
    test_flush_restore();
    test_flush_with_commit();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
